// File: rtl/contador_de_programa.sv
// Program counter and fetch sequencer in front of a combinational-read instruction memory.
// Qualifies each fetched word for decode and handles stalls, branches, IN waits and HALT.
module contador_de_programa #(
    parameter int unsigned RESET_ADDR  = 1,
    parameter int unsigned MAX_ADDR    = 150,
    parameter int unsigned INIT_CYCLES = 1,
    parameter int unsigned OPC_HALT    = 18,
    parameter int unsigned OPC_IN      = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        pausa,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    input  logic        entrada_valida,
    output logic [31:0] endereco,
    output logic        instrucao_valida,
    output logic        aguardando_entrada,
    output logic        parado,
    output logic        erro_endereco
);

    localparam logic [1:0] StInit    = 2'd0;
    localparam logic [1:0] StBusca   = 2'd1;
    localparam logic [1:0] StEspera  = 2'd2;
    localparam logic [1:0] StParado  = 2'd3;

    localparam logic [4:0]  OpcHalt  = 5'(OPC_HALT);
    localparam logic [4:0]  OpcIn    = 5'(OPC_IN);
    localparam logic [31:0] AddrMax  = 32'(MAX_ADDR);
    localparam logic [31:0] AddrRst  = 32'(RESET_ADDR);
    localparam logic [3:0]  InitLast = 4'(INIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        erro_q, erro_d;

    logic [4:0]  opc;
    logic        is_halt;
    logic        is_in;
    logic [31:0] pc_inc;
    logic [31:0] pc_cand;
    logic        cand_ok;
    logic        unused_bits;

    assign opc         = instrucao[31:27];
    assign is_halt     = (opc == OpcHalt);
    assign is_in       = (opc == OpcIn);
    assign unused_bits = ^instrucao[26:0];
    assign pc_inc      = pc_q + 32'd1;

    // Branch target only counts for ordinary instructions retiring from BUSCA.
    assign pc_cand = (state_q == StBusca && !is_in && desvio) ? alvo_desvio : pc_inc;
    assign cand_ok = (pc_cand != 32'd0) && (pc_cand <= AddrMax);

    always_comb begin
        instrucao_valida = 1'b0;
        case (state_q)
            StBusca:  instrucao_valida = !pausa && !(is_in && !entrada_valida);
            StEspera: instrucao_valida = !pausa && entrada_valida;
            default:  instrucao_valida = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        erro_d  = erro_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == InitLast) begin
                    state_d = StBusca;
                end
            end
            StBusca: begin
                if (!pausa) begin
                    if (is_halt) begin
                        state_d = StParado;
                    end else if (is_in && !entrada_valida) begin
                        state_d = StEspera;
                    end else if (cand_ok) begin
                        pc_d = pc_cand;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = StParado;
                    end
                end
            end
            StEspera: begin
                if (!pausa && entrada_valida) begin
                    if (cand_ok) begin
                        pc_d    = pc_cand;
                        state_d = StBusca;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = StParado;
                    end
                end
            end
            default: begin
                state_d = StParado;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
            pc_q    <= AddrRst;
            cnt_q   <= 4'd0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            erro_q  <= erro_d;
        end
    end

    assign endereco           = pc_q;
    assign aguardando_entrada = (state_q == StEspera);
    assign parado             = (state_q == StParado);
    assign erro_endereco      = erro_q;

endmodule
